// File: rtl/dmul_rot_param.sv
// Rotation-based unary multiplier: thermometer stream A against a slowly stepped stream B, counted over N*N cycles.
// Build option DMUL_ROT_PARAM_BIPOLAR_EN selects XNOR (bipolar) counting instead of AND (unipolar).
module dmul_rot_param #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [W-1:0]   iA,
    input  logic [W-1:0]   iB,
    output logic           ready,
    output logic           busy,
    output logic           done,
    output logic           oBit,
    output logic [2*W:0]   oC
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_a_q, cnt_a_d;
    logic [W-1:0]   cnt_b_q, cnt_b_d;
    logic [W-1:0]   a_buf_q, a_buf_d;
    logic [W-1:0]   b_buf_q, b_buf_d;
    logic [2*W:0]   oc_q, oc_d;
    logic [2*W:0]   oc_sum;
    logic           a_bit, b_bit, prod_bit;
    logic           a_wrap, last_cycle;

    assign a_bit      = (a_buf_q > cnt_a_q);
    assign b_bit      = (b_buf_q > cnt_b_q);
    assign a_wrap     = (cnt_a_q == {W{1'b1}});
    assign last_cycle = a_wrap && (cnt_b_q == {W{1'b1}});

`ifdef DMUL_ROT_PARAM_BIPOLAR_EN
    assign prod_bit = ~(a_bit ^ b_bit);
`else
    assign prod_bit = a_bit & b_bit;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            a_buf_q <= '0;
            b_buf_q <= '0;
            oc_q    <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            a_buf_q <= a_buf_d;
            b_buf_q <= b_buf_d;
            oc_q    <= oc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_RUN;
            end
            S_RUN: begin
                if (abort)           state_d = S_IDLE;
                else if (last_cycle) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The top count bit only carries information in the bipolar build.
    always_comb begin
        oc_sum = oc_q + {{(2*W){1'b0}}, prod_bit};
`ifndef DMUL_ROT_PARAM_BIPOLAR_EN
        oc_sum[2*W] = 1'b0;
`endif
    end

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        oc_d    = oc_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_buf_d = iA;
                    b_buf_d = iB;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                    oc_d    = '0;
                end
            end
            S_RUN: begin
                if (abort) begin
                    oc_d = '0;
                end else begin
                    cnt_a_d = cnt_a_q + W'(1);
                    if (a_wrap) cnt_b_d = cnt_b_q + W'(1);
                    oc_d = oc_sum;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (state_q == S_IDLE);
        busy  = (state_q == S_RUN);
        done  = (state_q == S_DONE);
        oBit  = (state_q == S_RUN) && prod_bit;
    end

    assign oC = oc_q;

endmodule

// File: tb/tb_dmul_rot_param.sv
// Directed and random bench for dmul_rot_param at W=4; expected products come from plain arithmetic.
module tb_dmul_rot_param;

    localparam int W  = 4;
    localparam int N  = 1 << W;
    localparam int RUN_LAT = N * N + 1;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [W-1:0]   iA = '0;
    logic [W-1:0]   iB = '0;
    logic           ready, busy, done, oBit;
    logic [2*W:0]   oC;

    int n_asserts = 0;
    int n_fails   = 0;

    dmul_rot_param #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .abort (abort),
        .iA    (iA),
        .iB    (iB),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .oBit  (oBit),
        .oC    (oC)
    );

    always #5 clk = ~clk;

    function automatic int model_prod(input int a, input int b);
`ifdef DMUL_ROT_PARAM_BIPOLAR_EN
        return a * b + (N - a) * (N - b);
`else
        return a * b;
`endif
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag, input int exp_oc);
        check({tag, "_ready"}, int'(ready), 1);
        check({tag, "_busy"},  int'(busy),  0);
        check({tag, "_done"},  int'(done),  0);
        check({tag, "_obit"},  int'(oBit),  0);
        check({tag, "_oc"},    int'(oC),    exp_oc);
    endtask

    // One full run; spam keeps start high and scrambles the operand inputs throughout.
    task automatic do_run(input string tag, input int a, input int b, input bit spam,
                          input bit with_abort);
        int cycles;
        int bitsum;
        int exp;
        exp = model_prod(a, b);
        @(negedge clk);
        iA = W'(a);
        iB = W'(b);
        start = 1'b1;
        abort = with_abort;
        @(posedge clk);
        #1;
        abort = 1'b0;
        if (!spam) start = 1'b0;
        check({tag, "_busy_after_accept"}, int'(busy), 1);
        check({tag, "_ready_after_accept"}, int'(ready), 0);
        cycles = 1;
        bitsum = 0;
        while (!done && cycles < RUN_LAT + 20) begin
            if (busy) bitsum += int'(oBit);
            if (spam) begin
                iA = W'($urandom);
                iB = W'($urandom);
            end
            @(posedge clk);
            #1;
            cycles++;
        end
        start = 1'b0;
        check({tag, "_latency"}, cycles, RUN_LAT);
        check({tag, "_oc_at_done"}, int'(oC), exp);
        check({tag, "_bitsum"}, bitsum, exp);
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, int'(done), 0);
        check({tag, "_ready_after"}, int'(ready), 1);
        check({tag, "_oc_hold"}, int'(oC), exp);
    endtask

    initial begin
        int ra, rb;
        int seen_done;

        // Reset values while rst_n is low
        #2;
        check_idle_outputs("reset", 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle_outputs("post_reset", 0);

        do_run("max", 15, 15, 1'b0, 1'b0);
        do_run("8x4", 8, 4, 1'b0, 1'b0);
        do_run("0x9", 0, 9, 1'b0, 1'b0);
        do_run("spam", 6, 11, 1'b1, 1'b0);
        do_run("abort_start_idle", 3, 13, 1'b0, 1'b1);

        // Abort at RUN cycle 100
        @(negedge clk);
        iA = 5; iB = 7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (99) begin
            iA = W'($urandom);
            @(posedge clk);
            #1;
        end
        check("abort_busy_before", int'(busy), 1);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_idle_outputs("abort", 0);
        seen_done = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            seen_done += int'(done);
        end
        check("abort_no_done", seen_done, 0);
        do_run("after_abort", 5, 7, 1'b0, 1'b0);

        // Abort outside RUN leaves the held result alone
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_idle_outputs("abort_idle", model_prod(5, 7));

        // Reset mid-run at RUN cycle 50
        @(negedge clk);
        iA = 12; iB = 10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) begin
            @(posedge clk);
            #1;
        end
        check("rst_busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_mid", 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            seen_done += int'(done);
        end
        check("rst_no_done", seen_done, 0);
        check_idle_outputs("rst_release", 0);

`ifdef DMUL_ROT_PARAM_BIPOLAR_EN
        do_run("bip_0x0", 0, 0, 1'b0, 1'b0);
        do_run("bip_8x8", 8, 8, 1'b0, 1'b0);
        do_run("bip_15x0", 15, 0, 1'b0, 1'b0);
`endif

        for (int k = 0; k < 5; k++) begin
            ra = int'($urandom_range(N - 1, 0));
            rb = int'($urandom_range(N - 1, 0));
            do_run("random", ra, rb, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
